buzzer_driver: RTL and testbench
================================

# buzzer_driver

- Consumer of the alarm comparator's `ring` level; turns it into a beeping buzzer drive with stop and snooze handling.
- Sits between the alarm block and the board buzzer pin.
- Detects the rising edge of `ring`, beeps in a fixed on/off pattern, and can be stopped or snoozed by debounced button pulses.
- Stops automatically after a timeout.

## Interface
Parameters:
- BEEP_ON_CYC, 500: cycles buzzer is high per beep period (≥1)
- BEEP_OFF_CYC, 500: cycles buzzer is low per beep period (≥1)
- RING_TIMEOUT_CYC, 60000: cycles of continuous RINGING before auto-stop (≥1)
- SNOOZE_CYC, 300000: cycles spent in SNOOZE before re-ringing (≥1)
- MAX_SNOOZE, 3: maximum snoozes per alarm event (0..3)

Ports:
- clk  input  1  system clock (mclk); all logic on rising edge
- rst  input  1  synchronous, active-low reset
- en  input  1  alarm enable; low forces IDLE
- ring  input  1  level from alarm comparator; high while alarm minute matches
- btn_stop  input  1  single-cycle pulse, debounced
- btn_snooze  input  1  single-cycle pulse, debounced
- buzzer  output  1  buzzer drive, registered
- ringing  output  1  high in RINGING
- snoozing  output  1  high in SNOOZE
- snooze_count  output  2  snoozes used in current alarm event

## Operation
- States: IDLE, RINGING, SNOOZE. Internal regs:
  - ring_prev
  - beep_cnt, phase bit
  - ring_cnt, snz_cnt (32-bit each)
- Trigger is `ring & ~ring_prev`.
  - ring_prev resets to 1, so a `ring` that is already high at reset release does not trigger.
- IDLE:
  - buzzer = 0, snooze_count = 0.
  - trigger with en = 1 → RINGING; beep phase = ON, beep_cnt = 0, ring_cnt = 0.
- RINGING:
  - buzzer follows phase: ON for BEEP_ON_CYC cycles, then OFF for BEEP_OFF_CYC cycles, repeating.
  - ring_cnt increments each cycle.
  - btn_stop → IDLE.
  - btn_snooze with snooze_count < MAX_SNOOZE → SNOOZE; snooze_count++, snz_cnt = 0.
  - btn_snooze with snooze_count == MAX_SNOOZE → ignored, keeps ringing.
  - ring_cnt reaching RING_TIMEOUT_CYC-1 → IDLE.
- SNOOZE:
  - buzzer = 0.
  - btn_stop → IDLE.
  - snz_cnt reaching SNOOZE_CYC-1 → RINGING, with beep phase, beep_cnt and ring_cnt restarted.
  - Further `ring` edges are ignored.
- Priority, highest first: rst low > en low (→ IDLE, all outputs 0 except ring_prev tracking) > btn_stop > timeout/snooze expiry > btn_snooze.
- Stopping does not re-arm within the same `ring` high period; re-trigger needs `ring` to fall and rise again.
- Counters are 32-bit unsigned; they never wrap, because state exits at terminal count.

## Timing
- Reset values: buzzer 0, ringing 0, snoozing 0, snooze_count 0, state IDLE, ring_prev 1.
- Trigger sampled at edge n → ringing = 1 and buzzer = 1 from cycle n+1.
- Beep pattern from RINGING entry cycle k:
  - buzzer high for cycles k .. k+BEEP_ON_CYC-1.
  - buzzer low for the next BEEP_OFF_CYC cycles.
  - Period is BEEP_ON_CYC + BEEP_OFF_CYC.
- Any exit from RINGING takes effect the next cycle; buzzer is 0 that cycle.
- Timeout: RINGING lasts exactly RING_TIMEOUT_CYC cycles if not interrupted.
- SNOOZE lasts exactly SNOOZE_CYC cycles if not stopped.
- btn_stop and btn_snooze in the same cycle resolve as stop.

## Test plan
Test parameters: BEEP_ON_CYC=2, BEEP_OFF_CYC=3, RING_TIMEOUT_CYC=20, SNOOZE_CYC=10, MAX_SNOOZE=2.
- Reset/trigger:
  - rst low 3 cycles with ring = 1, then release → no ringing.
  - Drop ring, raise it at cycle t → ringing = 1 at t+1.
  - buzzer reads 1,1,0,0,0,1,1,…
- Timeout:
  - Trigger with no buttons → ringing high exactly 20 cycles, then IDLE.
  - buzzer 0 afterwards even though ring is still high.
- Snooze cycle:
  - Snooze at RINGING cycle 4 → snoozing = 1 for 10 cycles, buzzer 0.
  - Then RINGING again with buzzer 1,1,0,…; snooze_count = 1.
- Snooze limit:
  - Two snoozes succeed; a third btn_snooze during RINGING is ignored (snooze_count stays 2).
  - btn_stop then → IDLE, snooze_count = 0.
- Simultaneous/stop:
  - btn_stop and btn_snooze in the same cycle → IDLE.
  - btn_stop during SNOOZE → IDLE.
  - While ring is still high, no re-trigger until ring falls and rises again.
- Enable/reset mid-operation:
  - en low during RINGING → all outputs 0 next cycle.
  - rst low during SNOOZE → reset values next cycle.

Source files
------------

// File: rtl/buzzer_driver.sv
// buzzer_driver: turns the alarm comparator's ring level into a beeping buzzer
// drive with stop, snooze (limited count) and automatic timeout handling.
module buzzer_driver #(
    parameter int BEEP_ON_CYC      = 500,
    parameter int BEEP_OFF_CYC     = 500,
    parameter int RING_TIMEOUT_CYC = 60000,
    parameter int SNOOZE_CYC       = 300000,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ring,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    localparam logic [1:0] SNOOZE  = 2'd2;

    // Terminal counts: each counter runs 0..N-1 and the state leaves on N-1.
    localparam logic [31:0] ON_LAST     = 32'(BEEP_ON_CYC - 1);
    localparam logic [31:0] OFF_LAST    = 32'(BEEP_OFF_CYC - 1);
    localparam logic [31:0] RING_LAST   = 32'(RING_TIMEOUT_CYC - 1);
    localparam logic [31:0] SNOOZE_LAST = 32'(SNOOZE_CYC - 1);
    localparam logic [1:0]  SNZ_MAX     = 2'(MAX_SNOOZE);

    logic [1:0]  state, state_n;
    logic        ring_prev;
    logic        phase, phase_n;          // 1 = beep ON half of the period
    logic [31:0] beep_cnt, beep_cnt_n;
    logic [31:0] ring_cnt, ring_cnt_n;
    logic [31:0] snz_cnt, snz_cnt_n;
    logic [1:0]  count_n;
    logic        trigger;

    // Only a fresh rising edge of ring starts an alarm; ring_prev resets high
    // so a level already present at reset release is not treated as an edge.
    assign trigger = ring & ~ring_prev;

    // Next-state logic: en low > stop > timeout/snooze expiry > snooze request.
    always_comb begin
        state_n    = state;
        phase_n    = phase;
        beep_cnt_n = beep_cnt;
        ring_cnt_n = ring_cnt;
        snz_cnt_n  = snz_cnt;
        count_n    = snooze_count;
        if (!en) begin
            state_n = IDLE;
            count_n = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    count_n = 2'd0;
                    if (trigger) begin
                        state_n    = RINGING;
                        phase_n    = 1'b1;
                        beep_cnt_n = 32'd0;
                        ring_cnt_n = 32'd0;
                    end
                end
                RINGING: begin
                    if (phase) begin
                        if (beep_cnt == ON_LAST) begin
                            phase_n    = 1'b0;
                            beep_cnt_n = 32'd0;
                        end else begin
                            beep_cnt_n = beep_cnt + 32'd1;
                        end
                    end else begin
                        if (beep_cnt == OFF_LAST) begin
                            phase_n    = 1'b1;
                            beep_cnt_n = 32'd0;
                        end else begin
                            beep_cnt_n = beep_cnt + 32'd1;
                        end
                    end
                    ring_cnt_n = ring_cnt + 32'd1;
                    if (btn_stop) begin
                        state_n = IDLE;
                        count_n = 2'd0;
                    end else if (ring_cnt == RING_LAST) begin
                        state_n = IDLE;
                        count_n = 2'd0;
                    end else if (btn_snooze && (snooze_count < SNZ_MAX)) begin
                        state_n   = SNOOZE;
                        count_n   = snooze_count + 2'd1;
                        snz_cnt_n = 32'd0;
                    end
                end
                SNOOZE: begin
                    snz_cnt_n = snz_cnt + 32'd1;
                    if (btn_stop) begin
                        state_n = IDLE;
                        count_n = 2'd0;
                    end else if (snz_cnt == SNOOZE_LAST) begin
                        state_n    = RINGING;
                        phase_n    = 1'b1;
                        beep_cnt_n = 32'd0;
                        ring_cnt_n = 32'd0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    count_n = 2'd0;
                end
            endcase
        end
    end

    // State, counters and registered outputs (outputs derived from next state).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            ring_prev    <= 1'b1;
            phase        <= 1'b0;
            beep_cnt     <= 32'd0;
            ring_cnt     <= 32'd0;
            snz_cnt      <= 32'd0;
            snooze_count <= 2'd0;
            buzzer       <= 1'b0;
            ringing      <= 1'b0;
            snoozing     <= 1'b0;
        end else begin
            state        <= state_n;
            ring_prev    <= ring;
            phase        <= phase_n;
            beep_cnt     <= beep_cnt_n;
            ring_cnt     <= ring_cnt_n;
            snz_cnt      <= snz_cnt_n;
            snooze_count <= count_n;
            buzzer       <= (state_n == RINGING) && phase_n;
            ringing      <= (state_n == RINGING);
            snoozing     <= (state_n == SNOOZE);
        end
    end

endmodule

// File: tb/tb_buzzer_driver.sv
// Scoreboard bench for buzzer_driver: the stimulus process pushes the expected
// outputs for every clock edge, a monitor pops and compares after each edge.
module tb_buzzer_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       ring = 1'b1;
    logic       btn_stop = 1'b0;
    logic       btn_snooze = 1'b0;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_count;

    int total = 0;
    int bad   = 0;
    int test_id = 0;
    int step_id = 0;

    logic [4:0] exp_q[$];
    int         tag_q[$];

    buzzer_driver #(
        .BEEP_ON_CYC(2),
        .BEEP_OFF_CYC(3),
        .RING_TIMEOUT_CYC(20),
        .SNOOZE_CYC(10),
        .MAX_SNOOZE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .ring(ring),
        .btn_stop(btn_stop),
        .btn_snooze(btn_snooze),
        .buzzer(buzzer),
        .ringing(ringing),
        .snoozing(snoozing),
        .snooze_count(snooze_count)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per clock edge, checked 1 time unit later.
    initial begin
        logic [4:0] e;
        int         t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                total++;
                if ({buzzer, ringing, snoozing, snooze_count} !== e) begin
                    bad++;
                    $display("FAIL test%0d step%0d buz/ring/snz/cnt: got %b/%b/%b/%0d required %b/%b/%b/%0d",
                             t / 1000, t % 1000, buzzer, ringing, snoozing, snooze_count,
                             e[4], e[3], e[2], e[1:0]);
                end
            end
        end
    end

    // One clock: apply button pulses, queue expected outputs after the edge.
    task automatic tick(input logic stop, input logic snz, input logic eb,
                        input logic er, input logic es, input logic [1:0] ec);
        btn_stop   = stop;
        btn_snooze = snz;
        exp_q.push_back({eb, er, es, ec});
        tag_q.push_back(test_id * 1000 + step_id);
        step_id++;
        @(posedge clk);
        #2;
        btn_stop   = 1'b0;
        btn_snooze = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    // Beep pattern 1,1,0,0,0 repeating from RINGING entry (index 0).
    task automatic ring_run(input int n, input int start, input logic [1:0] c);
        for (int i = 0; i < n; i++)
            tick(1'b0, 1'b0, (((start + i) % 5) < 2), 1'b1, 1'b0, c);
    endtask

    task automatic snooze_run(input int n, input logic [1:0] c);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c);
    endtask

    task automatic new_test(input int id);
        test_id = id;
        step_id = 0;
    endtask

    initial begin
        // 1: reset with ring high, release: no trigger
        new_test(1);
        rst = 1'b0; ring = 1'b1; en = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(3);

        // 2: rising edge triggers, full beep pattern, timeout after 20 cycles
        new_test(2);
        ring = 1'b0; idle(1);
        ring = 1'b1;
        ring_run(20, 0, 2'd0);
        idle(4);

        // 3: snooze, re-ring, snooze limit, stop clears count
        new_test(3);
        ring = 1'b0; idle(1);
        ring = 1'b1;
        ring_run(4, 0, 2'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        snooze_run(9, 2'd1);
        ring_run(3, 0, 2'd1);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2);
        snooze_run(9, 2'd2);
        ring_run(2, 0, 2'd2);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
        ring_run(1, 3, 2'd2);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        idle(2);

        // 4: stop and snooze together resolve as stop; no re-trigger while high
        new_test(4);
        ring = 1'b0; idle(1);
        ring = 1'b1;
        ring_run(3, 0, 2'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        idle(3);

        // 5: ring edges ignored in SNOOZE, stop during SNOOZE
        new_test(5);
        ring = 1'b0; idle(1);
        ring = 1'b1;
        ring_run(2, 0, 2'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        snooze_run(2, 2'd1);
        ring = 1'b0; snooze_run(1, 2'd1);
        ring = 1'b1; snooze_run(1, 2'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        idle(2);

        // 6: en low during RINGING, and en low blocks a trigger in IDLE
        new_test(6);
        ring = 1'b0; idle(1);
        ring = 1'b1;
        ring_run(3, 0, 2'd0);
        en = 1'b0;
        idle(2);
        ring = 1'b0; idle(1);
        ring = 1'b1; idle(1);
        en = 1'b1;
        idle(2);

        // 7: reset during SNOOZE, then a clean trigger still works
        new_test(7);
        ring = 1'b0; idle(1);
        ring = 1'b1;
        ring_run(1, 0, 2'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
        snooze_run(2, 2'd1);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(2);
        ring = 1'b0; idle(1);
        ring = 1'b1;
        ring_run(2, 0, 2'd0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        idle(1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d entries left required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
